// File: rtl/map_sw_pkg.sv
// Shared types and widths for the mapper-switch controller and its helpers.
package map_sw_pkg;

  localparam int IDX_W = 8;
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_M2 = 3'd1,
    ST_HOLD    = 3'd2,
    ST_SWITCH  = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  // Cycle counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/map_sw_edge.sv
// M2 edge detector: one-cycle fall/rise pulses from the already-synchronized M2 phase.
module map_sw_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic m2,
  output logic fall,
  output logic rise
);

  logic m2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_q <= 1'b0;
    end else begin
      m2_q <= m2;
    end
  end

  assign fall = m2_q & ~m2;
  assign rise = ~m2_q & m2;

endmodule

// File: rtl/map_switch_ctrl.sv
// Mapper switch sequencer: waits for M2 low, resets the mappers, swaps the index, releases on M2 high.
// Optional M2 wait timeout is enabled with `define MAP_SWITCH_TIMEOUT_EN.
module map_switch_ctrl
  import map_sw_pkg::*;
#(
  parameter int unsigned DEF_IDX    = 0,
  parameter int unsigned RST_CYC    = 16,
  parameter int unsigned M2_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [IDX_W-1:0] req_idx,
  input  logic             m2,
  output logic [IDX_W-1:0] map_idx,
  output logic             map_rst,
  output logic             bus_hold,
  output logic             busy,
  output logic             ack,
  output logic             drop,
  output logic             tmo
);

  if (RST_CYC < 1 || RST_CYC > 255) begin : g_bad_rst_cyc
    $error("map_switch_ctrl: RST_CYC must be within 1..255");
  end
  if (M2_TIMEOUT < 1 || M2_TIMEOUT > 65535) begin : g_bad_m2_timeout
    $error("map_switch_ctrl: M2_TIMEOUT must be within 1..65535");
  end

  localparam logic [IDX_W-1:0] DEF_IDX_C = IDX_W'(DEF_IDX);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] pend_idx_q;
  logic [IDX_W-1:0] map_idx_q;
  logic             map_rst_q;
  logic             bus_hold_q;
  logic             busy_q;
  logic             ack_q;
  logic             drop_q;
  logic             m2_fall;
  logic             m2_rise;
  logic             wait_expired;
  logic             accept;

  map_sw_edge u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .m2    (m2),
    .fall  (m2_fall),
    .rise  (m2_rise)
  );

`ifdef MAP_SWITCH_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(M2_TIMEOUT - 1);
  logic tmo_q;

  assign wait_expired = (cnt_q == TMO_LAST);
  assign tmo          = tmo_q;
`else
  assign wait_expired = 1'b0;
  assign tmo          = 1'b0;
`endif

  assign accept = (state_q == ST_IDLE) && req;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (req) state_d = ST_WAIT_M2;
      ST_WAIT_M2: if (m2_fall || wait_expired) state_d = ST_HOLD;
      ST_HOLD:    if (cnt_q == HOLD_LAST) state_d = ST_SWITCH;
      ST_SWITCH:  state_d = ST_RELEASE;
      ST_RELEASE: if (m2_rise) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // The counter only matters in WAIT_M2 and HOLD; it restarts from zero on every state entry.
  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && (state_q == ST_WAIT_M2 || state_q == ST_HOLD)) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pend_idx_q <= DEF_IDX_C;
      map_idx_q  <= DEF_IDX_C;
      map_rst_q  <= 1'b0;
      bus_hold_q <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      drop_q     <= 1'b0;
`ifdef MAP_SWITCH_TIMEOUT_EN
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= (state_d != ST_IDLE);
      bus_hold_q <= (state_d == ST_HOLD) || (state_d == ST_SWITCH) || (state_d == ST_RELEASE);
      map_rst_q  <= (state_d == ST_HOLD) || (state_d == ST_SWITCH);
      ack_q      <= (state_q == ST_RELEASE) && (state_d == ST_IDLE);

      if (accept) begin
        pend_idx_q <= req_idx;
      end
      if (state_d == ST_SWITCH) begin
        map_idx_q <= pend_idx_q;
      end

      if (accept) begin
        drop_q <= 1'b0;
      end else if (req && (state_q != ST_IDLE)) begin
        drop_q <= 1'b1;
      end

`ifdef MAP_SWITCH_TIMEOUT_EN
      // A real fall wins over an expiry landing on the same cycle.
      if (accept) begin
        tmo_q <= 1'b0;
      end else if ((state_q == ST_WAIT_M2) && wait_expired && !m2_fall) begin
        tmo_q <= 1'b1;
      end
`endif
    end
  end

  assign map_idx  = map_idx_q;
  assign map_rst  = map_rst_q;
  assign bus_hold = bus_hold_q;
  assign busy     = busy_q;
  assign ack      = ack_q;
  assign drop     = drop_q;

endmodule
